dmem_responder: RTL and testbench

- Responder end of the data-memory interface driven by the memory-access stage.
- Accepts single-word read/write requests over a req/ack handshake.
- Inserts a configurable number of wait states, then performs the access on a registered word array and returns read data.
- Replaces the zero-latency combinational data memory, so the pipeline can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_wait_counter.sv | 27 ++
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Read/write access counters are enabled by defining DMEM_ACCESS_CNT_EN.
package dmem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int WS_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable wait-state down-counter; zero flags the terminal count.
module dmem_wait_counter
    import dmem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [WS_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake, WAIT_STATES wait cycles, registered word array.
// Defining DMEM_ACCESS_CNT_EN adds saturating rd_count/wr_count outputs.
//
// state | meaning
// IDLE  | waiting for req; accepts and latches the request
// WAIT  | burning wait states on the down-counter
// RESP  | ack cycle; access was performed on entry, req ignored
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned     MEM_WORDS = 1 << DEPTH_LOG2;
    localparam logic [WS_W-1:0] WS_LOAD   = WS_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dmem_state_t state, state_nxt;

    logic              accept;
    logic              enter_resp;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic [DEPTH_LOG2-1:0] idx;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    dmem_wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WS_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_load  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, before the latches update.
    assign acc_we    = accept ? we    : we_l;
    assign acc_addr  = accept ? addr  : addr_l;
    assign acc_wdata = accept ? wdata : wdata_l;
    assign in_range  = (32'(acc_addr) < MEM_WORDS);
    assign idx       = acc_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
        end else begin
            ack <= enter_resp;
            err <= enter_resp && !in_range;
            if (accept) begin
                we_l    <= we;
                addr_l  <= addr;
                wdata_l <= wdata;
                busy    <= 1'b1;
            end else if (state == RESP) begin
                busy <= 1'b0;
            end
            if (enter_resp) begin
                if (!in_range) begin
                    rdata <= '0;
                end else if (!acc_we) begin
                    rdata <= mem[idx];
                end
            end
        end
    end

    // Array is deliberately not reset; an async reset leaves the FSM in IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (enter_resp && in_range) begin
            if (acc_we) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
// Counter checks are included when DMEM_ACCESS_CNT_EN is defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req1 = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;

    logic        ack1, err1, busy1, ack0, err0, busy0;
    logic [15:0] rdata1, rdata0;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd1, wr1, rd0, wr0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd1), .wr_count(wr1)
`endif
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd0), .wr_count(wr0)
`endif
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts negedges until ack is seen; returns 0 if the bound expires.
    task automatic wait_ack(input bit sel, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel ? ack1 : ack0) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Full single access starting at a negedge; ends at a negedge with req low.
    task automatic access(input bit sel, input bit w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input bit exp_err, input string tag);
        int n;
        int exp_lat;
        exp_lat = sel ? 2 : 1;
        we = w;
        addr = a;
        wdata = d;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        chk(sel ? busy1 : busy0, 1, {tag, " busy"});
        n = 1;
        if ((sel ? ack1 : ack0) !== 1'b1) begin
            wait_ack(sel, n);
            if (n != 0) n = n + 1;
        end
        chk(n, exp_lat, {tag, " latency"});
        chk(sel ? rdata1 : rdata0, exp_rd, {tag, " rdata"});
        chk(sel ? err1 : err0, exp_err, {tag, " err"});
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        chk(sel ? {ack1, busy1} : {ack0, busy0}, 0, {tag, " ack/busy drop"});
    endtask

    int n;
    int acks;

    initial begin
        #3;
        chk({ack1, err1, busy1, rdata1}, 0, "reset outputs dut");
        chk({ack0, err0, busy0, rdata0}, 0, "reset outputs dut0");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        access(1, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, "wr 0x10");
        access(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, "rd 0x10");
        access(1, 1, 16'h0000, 16'h5A5A, 16'hBEEF, 0, "wr 0x00");

        access(0, 1, 16'h0003, 16'h1234, 16'h0000, 0, "ws0 wr 0x03");
        access(0, 0, 16'h0003, 16'h0000, 16'h1234, 0, "ws0 rd 0x03");

        access(1, 1, 16'h0100, 16'hFFFF, 16'h0000, 1, "oor wr 0x100");
        access(1, 0, 16'h0000, 16'h0000, 16'h5A5A, 0, "rd 0x00 after oor");
        access(1, 0, 16'h0100, 16'h0000, 16'h0000, 1, "oor rd 0x100");
        access(1, 1, 16'h0012, 16'h2222, 16'h0000, 0, "wr 0x12");

        // Inputs change after acceptance; latched copies must be used.
        we = 1'b1;
        addr = 16'h0011;
        wdata = 16'hCAFE;
        req1 = 1'b1;
        @(negedge clk);
        we = 1'b0;
        addr = 16'h0012;
        wdata = 16'h1111;
        @(negedge clk);
        chk(ack1, 1, "stable ack");
        chk(err1, 0, "stable err");
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);
        access(1, 0, 16'h0011, 16'h0000, 16'hCAFE, 0, "rd 0x11 latched");
        access(1, 0, 16'h0012, 16'h0000, 16'h2222, 0, "rd 0x12 untouched");

        // req held high through ack: second access accepted in the following IDLE cycle.
        we = 1'b0;
        addr = 16'h0010;
        req1 = 1'b1;
        wait_ack(1, n);
        chk(n, 2, "b2b first latency");
        chk(rdata1, 16'hBEEF, "b2b first rdata");
        addr = 16'h0011;
        wait_ack(1, n);
        chk(n, 3, "b2b second spacing");
        chk(rdata1, 16'hCAFE, "b2b second rdata");
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);

        access(1, 1, 16'h0020, 16'h3333, 16'hCAFE, 0, "wr 0x20");
        access(1, 0, 16'h0020, 16'h0000, 16'h3333, 0, "rd 0x20");

        // Reset during WAIT of a write abandons it.
        we = 1'b1;
        addr = 16'h0020;
        wdata = 16'h9999;
        req1 = 1'b1;
        @(negedge clk);
        chk(busy1, 1, "midreset busy before");
        #2;
        reset = 1'b1;
        #1;
        chk({ack1, err1, busy1, rdata1}, 0, "midreset async outputs");
        req1 = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1) acks++;
            if (i == 2) reset = 1'b0;
        end
        chk(acks, 0, "midreset no ack");
        access(1, 0, 16'h0020, 16'h0000, 16'h3333, 0, "rd 0x20 after reset");

        access(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, "cnt rd 0x10");
        access(1, 0, 16'h0011, 16'h0000, 16'hCAFE, 0, "cnt rd 0x11");
        access(1, 1, 16'h0030, 16'h0A0A, 16'hCAFE, 0, "cnt wr 0x30");
        access(1, 1, 16'h0031, 16'h0B0B, 16'hCAFE, 0, "cnt wr 0x31");
        access(1, 1, 16'h0200, 16'h0C0C, 16'h0000, 1, "cnt oor wr 0x200");
        access(1, 0, 16'h0030, 16'h0000, 16'h0A0A, 0, "rd 0x30");
`ifdef DMEM_ACCESS_CNT_EN
        chk(rd1, 4, "rd_count");
        chk(wr1, 2, "wr_count");
        chk({rd0, wr0}, 0, "dut0 counts after reset");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
